// File: rtl/mem_cmd_arbiter_if.sv
// mem_cmd_arbiter_if: command, status and monitor signals of mem_cmd_arbiter.
// "master" is the arbiter's view and "slave" is the surrounding system's view.
// grant_count exists only when MEM_CMD_ARB_STATS_EN is defined.
interface mem_cmd_arbiter_if #(
    parameter int NUM_REQ   = 2,
    parameter int TAG_DEPTH = 16
);
    // requester command ports (packed by requester)
    logic [NUM_REQ-1:0]        s_cmd_valid;
    logic [NUM_REQ-1:0]        s_cmd_ready;
    logic [NUM_REQ*64-1:0]     s_cmd_address;
    logic [NUM_REQ*32-1:0]     s_cmd_length;
    // datamover command port
    logic                      m_cmd_valid;
    logic                      m_cmd_ready;
    logic [63:0]               m_cmd_address;
    logic [31:0]               m_cmd_length;
    // datamover status port
    logic                      s_sts_valid;
    logic                      s_sts_ready;
    logic [7:0]                s_sts_data;
    // requester status ports
    logic [NUM_REQ-1:0]        m_sts_valid;
    logic [NUM_REQ-1:0]        m_sts_ready;
    logic [NUM_REQ*8-1:0]      m_sts_data;
    // monitors
    logic [$clog2(TAG_DEPTH):0] outstanding;
    logic                      err_orphan_sts;
`ifdef MEM_CMD_ARB_STATS_EN
    logic [NUM_REQ*32-1:0]     grant_count;
`endif

    modport master (
`ifdef MEM_CMD_ARB_STATS_EN
        output grant_count,
`endif
        input  s_cmd_valid, s_cmd_address, s_cmd_length, m_cmd_ready,
        input  s_sts_valid, s_sts_data, m_sts_ready,
        output s_cmd_ready, m_cmd_valid, m_cmd_address, m_cmd_length,
        output s_sts_ready, m_sts_valid, m_sts_data,
        output outstanding, err_orphan_sts
    );

    modport slave (
`ifdef MEM_CMD_ARB_STATS_EN
        input  grant_count,
`endif
        output s_cmd_valid, s_cmd_address, s_cmd_length, m_cmd_ready,
        output s_sts_valid, s_sts_data, m_sts_ready,
        input  s_cmd_ready, m_cmd_valid, m_cmd_address, m_cmd_length,
        input  s_sts_ready, m_sts_valid, m_sts_data,
        input  outstanding, err_orphan_sts
    );
endinterface

// File: rtl/mem_cmd_arbiter.sv
// mem_cmd_arbiter: round-robin sharing of one DMA/DDR command channel among
// NUM_REQ requesters. A tag FIFO records the grant order so that each status
// word goes back to the requester that issued the matching command.
// Optional feature: define MEM_CMD_ARB_STATS_EN to add per-requester grant
// counters on bus.grant_count.
module mem_cmd_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int TAG_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    mem_cmd_arbiter_if.master bus
);
    localparam int RW  = $clog2(NUM_REQ);
    localparam int RW1 = RW + 1;
    localparam int AW  = $clog2(TAG_DEPTH);
    localparam int AW1 = AW + 1;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_ISSUE = 1'b1;

    logic [0:0]    r_state;
    logic [RW-1:0] r_rr;
    logic [63:0]   r_addr;
    logic [31:0]   r_len;
    logic [RW-1:0] r_tag_mem [TAG_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_err;

    logic          w_any;
    logic [RW-1:0] w_gnt;
    logic [63:0]   w_addr;
    logic [31:0]   w_len;
    logic [RW-1:0] w_head;
    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_pop;

    // Round-robin search: first valid requester at or above r_rr, wrapping
    always_comb begin
        logic [RW:0] j;
        w_any = 1'b0;
        w_gnt = r_rr;
        j     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = {1'b0, r_rr} + RW1'(k);
            if (j >= RW1'(NUM_REQ))
                j = j - RW1'(NUM_REQ);
            if (!w_any && bus.s_cmd_valid[j[RW-1:0]]) begin
                w_any = 1'b1;
                w_gnt = j[RW-1:0];
            end
        end
    end

    // Select the granted requester's address/length
    always_comb begin
        w_addr = '0;
        w_len  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_gnt == RW'(k)) begin
                w_addr = bus.s_cmd_address[64*k +: 64];
                w_len  = bus.s_cmd_length[32*k +: 32];
            end
        end
    end

    // A full FIFO blocks the grant even if the head pops this cycle
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == AW1'(TAG_DEPTH));
    assign w_push  = !rst && (r_state == S_IDLE) && w_any && !w_full;
    assign w_head  = r_tag_mem[r_rd_ptr];
    assign w_pop   = bus.s_sts_valid && bus.s_sts_ready;

    // Handshake steering: only the granted requester and the head-tag owner see their lane
    always_comb begin
        bus.s_cmd_ready = '0;
        bus.m_sts_valid = '0;
        if (w_push)
            bus.s_cmd_ready[w_gnt] = 1'b1;
        if (!rst && !w_empty && bus.s_sts_valid)
            bus.m_sts_valid[w_head] = 1'b1;
    end

    assign bus.s_sts_ready    = !rst && !w_empty && bus.m_sts_ready[w_head];
    assign bus.m_sts_data     = {NUM_REQ{bus.s_sts_data}};
    assign bus.m_cmd_valid    = (r_state == S_ISSUE);
    assign bus.m_cmd_address  = r_addr;
    assign bus.m_cmd_length   = r_len;
    assign bus.outstanding    = r_count;
    assign bus.err_orphan_sts = r_err;

    // Command FSM: capture on accept, hold stable until the datamover takes it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_len   <= '0;
        end else if (r_state == S_IDLE) begin
            if (w_push) begin
                r_addr  <= w_addr;
                r_len   <= w_len;
                r_state <= S_ISSUE;
            end
        end else if (bus.m_cmd_ready) begin
            r_state <= S_IDLE;
        end
    end

    // Round-robin pointer moves just past the last granted requester
    always_ff @(posedge clk) begin
        if (rst)
            r_rr <= '0;
        else if (w_push)
            r_rr <= (w_gnt == RW'(NUM_REQ - 1)) ? '0 : w_gnt + RW'(1);
    end

    // Tag storage: grant index written in grant order
    always_ff @(posedge clk) begin
        if (w_push)
            r_tag_mem[r_wr_ptr] <= w_gnt;
    end

    // Tag FIFO pointers and outstanding count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + AW1'(1);
                2'b01:   r_count <= r_count - AW1'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky flag: status offered while nothing is outstanding
    always_ff @(posedge clk) begin
        if (rst)
            r_err <= 1'b0;
        else if (bus.s_sts_valid && w_empty)
            r_err <= 1'b1;
    end

`ifdef MEM_CMD_ARB_STATS_EN
    logic [NUM_REQ-1:0][31:0] r_gcnt;

    // Per-requester accepted-command counters, wrapping at 2^32
    always_ff @(posedge clk) begin
        if (rst)
            r_gcnt <= '0;
        else if (w_push)
            r_gcnt[w_gnt] <= r_gcnt[w_gnt] + 32'd1;
    end

    assign bus.grant_count = r_gcnt;
`else
    // Statistics disabled: no grant_count port and no counters.
`endif

endmodule
